cond_exec_stage: RTL and testbench
==================================

Name: cond_exec_stage

Overview:
- Decode-to-execute pipeline stage directly downstream of the control unit in the Filter-GPU core.
- Registers the decoded control word (RegW, MemW, MemToReg, ALUSrc, ALUControl, Cond, FlagW, PCS) with stall and flush support.
- Holds the architectural NZCV flags register and evaluates the 4-bit ARM condition field against it.
- Annuls RegW, MemW and PCS of instructions that fail their condition before they leave execute.

Parameters:
ALUC_W, 4, width of ALUControl field
CNT_W, 16, width of performance counters (optional feature only)

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous reset, active-low
StallE  in  1  hold E-stage register contents
FlushE  in  1  load a bubble into E stage
ValidD  in  1  decode slot holds a real instruction
RegWD  in  1  register write request from decode
MemWD  in  1  memory write request from decode
MemToRegD  in  1  writeback source select from decode
ALUSrcD  in  1  ALU operand B select from decode
PCSD  in  1  instruction writes PC (branch or Rd=PC)
FlagWD  in  2  [1]=update N,Z; [0]=update C,V
ALUControlD  in  ALUC_W  ALU operation from decode
CondD  in  4  condition field Instr[31:28]
ALUFlags  in  4  {N,Z,C,V} produced by ALU this cycle for the E-stage instruction
ValidE  out  1  E stage holds a real instruction
CondExE  out  1  condition passed (0 when ValidE=0)
RegWriteE  out  1  RegW_e & CondExE
MemWriteE  out  1  MemW_e & CondExE
PCSrcE  out  1  PCS_e & CondExE
MemToRegE  out  1  registered MemToRegD
ALUSrcE  out  1  registered ALUSrcD
ALUControlE  out  ALUC_W  registered ALUControlD
Flags  out  4  current NZCV register {N,Z,C,V}

Behaviour:
- Reset (RST=0, async): all E registers 0, ValidE=0, Flags=4'b0000, all outputs 0. Asynchronous reset mid-operation discards the in-flight instruction with no flag update.
- E-register update each rising CLK edge:
  - FlushE=1: load bubble (all fields 0, ValidE=0).
  - Else StallE=1: hold all fields.
  - Else: capture D inputs, ValidE<=ValidD.
  - FlushE has priority over StallE.
- Latency: decode signals appear on E outputs one cycle after capture.
- Condition evaluation is combinational on E-register Cond and current Flags, i.e. the pre-update value:
  - 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C; 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V.
  - 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT !Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1.
  - 1111 never (annulled).
- CondExE = ValidE & condition result. RegWriteE, MemWriteE and PCSrcE are gated by CondExE. MemToRegE, ALUSrcE and ALUControlE pass through ungated.
- Flags update at the rising edge when CondExE=1 and StallE=0:
  - FlagW_e[1]=1: N,Z <= ALUFlags[3:2].
  - FlagW_e[0]=1: C,V <= ALUFlags[1:0].
  - Flags never change in any other case, including bubbles, failed conditions and stalled cycles.
- A stalled instruction is evaluated again every cycle against unchanged flags, so its result stays stable.
- Back-to-back case: an instruction entering E on the cycle after a flag-setter sees the updated flags.

Optional Feature:
- Macro: COND_PERF_CNT_EN.
- With the macro defined:
  - Adds outputs ExecCnt and AnnulCnt, each CNT_W bits, both reset to 0.
  - On each edge with ValidE=1 and StallE=0, ExecCnt increments if CondExE=1, else AnnulCnt increments.
  - Counters wrap from all-ones to 0.
- Without the macro: the ports and counter logic are absent; all other behaviour is identical.

Test Plan:
- Reset: drive RST=0 mid-stream with ValidE=1 -> all outputs 0 and Flags=0000 immediately, without waiting for CLK.
- Flag set then conditional: ADDS (FlagWD=11, CondD=1110, ALUFlags=0100) -> Flags=0100 next cycle; following MOVEQ with RegWD=1, CondD=0000 -> RegWriteE=1; following MOVNE -> RegWriteE=0, CondExE=0, Flags unchanged.
- Signed compare: Flags=1000 (N=1, V=0) -> GE (1010) fails and LT (1011) passes. Flags=1001 -> GT (1100) passes. Cond=1111 -> CondExE=0 regardless of flags.
- Stall/flush: StallE=1 for 3 cycles with a flag-setting AL instruction in E -> E outputs held and Flags unchanged until StallE drops, then updated once. FlushE=1 together with StallE=1 -> ValidE=0 next cycle.
- Partial update: Flags=1111, FlagW=01, ALUFlags=0000 -> Flags=1100. Flags=1111, FlagW=10, ALUFlags=0000 -> Flags=0011.
- With COND_PERF_CNT_EN: 5 passing plus 3 failing valid instructions, one of them stalled 2 cycles -> ExecCnt=5, AnnulCnt=3. Preload ExecCnt to 16'hFFFF and execute once -> ExecCnt=0.

Source files
------------

// File: rtl/cond_exec_stage.sv
// cond_exec_stage: E-stage control register with NZCV flags and ARM condition annulment.
// Define COND_PERF_CNT_EN to add the ExecCnt/AnnulCnt performance counters.
module cond_exec_stage #(
  parameter int ALUC_W = 4
`ifdef COND_PERF_CNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              StallE,
  input  logic              FlushE,
  input  logic              ValidD,
  input  logic              RegWD,
  input  logic              MemWD,
  input  logic              MemToRegD,
  input  logic              ALUSrcD,
  input  logic              PCSD,
  input  logic [1:0]        FlagWD,
  input  logic [ALUC_W-1:0] ALUControlD,
  input  logic [3:0]        CondD,
  input  logic [3:0]        ALUFlags,
  output logic              ValidE,
  output logic              CondExE,
  output logic              RegWriteE,
  output logic              MemWriteE,
  output logic              PCSrcE,
  output logic              MemToRegE,
  output logic              ALUSrcE,
  output logic [ALUC_W-1:0] ALUControlE,
  output logic [3:0]        Flags
`ifdef COND_PERF_CNT_EN
  , output logic [CNT_W-1:0] ExecCnt
  , output logic [CNT_W-1:0] AnnulCnt
`endif
);
  logic              valid_e, regw_e, memw_e, mtr_e, alusrc_e, pcs_e;
  logic [1:0]        flagw_e;
  logic [ALUC_W-1:0] aluc_e;
  logic [3:0]        cond_e, flags;
  logic              base, cond_ok;
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      {valid_e, regw_e, memw_e, mtr_e, alusrc_e, pcs_e} <= '0;
      flagw_e <= '0;
      aluc_e  <= '0;
      cond_e  <= '0;
    end else if (FlushE) begin
      {valid_e, regw_e, memw_e, mtr_e, alusrc_e, pcs_e} <= '0;
      flagw_e <= '0;
      aluc_e  <= '0;
      cond_e  <= '0;
    end else if (!StallE) begin
      {valid_e, regw_e, memw_e, mtr_e, alusrc_e, pcs_e} <= {ValidD, RegWD, MemWD, MemToRegD, ALUSrcD, PCSD};
      flagw_e <= FlagWD;
      aluc_e  <= ALUControlD;
      cond_e  <= CondD;
    end
  end
  // Odd condition codes are the inverse of their even partner; 1111 inverts AL into never.
  always_comb begin
    base = 1'b1;
    case (cond_e[3:1])
      3'b000: base = flags[2];
      3'b001: base = flags[1];
      3'b010: base = flags[3];
      3'b011: base = flags[0];
      3'b100: base = flags[1] & ~flags[2];
      3'b101: base = flags[3] == flags[0];
      3'b110: base = ~flags[2] & (flags[3] == flags[0]);
      default: base = 1'b1;
    endcase
    cond_ok = base ^ cond_e[0];
  end
  assign ValidE      = valid_e;
  assign CondExE     = valid_e & cond_ok;
  assign RegWriteE   = regw_e & CondExE;
  assign MemWriteE   = memw_e & CondExE;
  assign PCSrcE      = pcs_e & CondExE;
  assign MemToRegE   = mtr_e;
  assign ALUSrcE     = alusrc_e;
  assign ALUControlE = aluc_e;
  assign Flags       = flags;
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) flags <= '0;
    else if (CondExE && !StallE) begin
      if (flagw_e[1]) flags[3:2] <= ALUFlags[3:2];
      if (flagw_e[0]) flags[1:0] <= ALUFlags[1:0];
    end
  end
`ifdef COND_PERF_CNT_EN
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ExecCnt  <= '0;
      AnnulCnt <= '0;
    end else if (valid_e && !StallE) begin
      if (CondExE) ExecCnt <= ExecCnt + 1'b1;
      else AnnulCnt <= AnnulCnt + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_cond_exec_stage.sv
// tb_cond_exec_stage: directed and randomized checks of cond_exec_stage against a behavioural model.
module tb_cond_exec_stage;
  logic CLK = 0, RST = 0;
  logic StallE = 0, FlushE = 0, ValidD = 0, RegWD = 0, MemWD = 0, MemToRegD = 0, ALUSrcD = 0, PCSD = 0;
  logic [1:0] FlagWD = 0;
  logic [3:0] ALUControlD = 0, CondD = 0, ALUFlags = 0;
  logic ValidE, CondExE, RegWriteE, MemWriteE, PCSrcE, MemToRegE, ALUSrcE;
  logic [3:0] ALUControlE, Flags;
`ifdef COND_PERF_CNT_EN
  logic [15:0] ExecCnt, AnnulCnt, m_exec, m_annul;
`endif
  int total = 0, bad = 0;
  logic m_valid, m_regw, m_memw, m_mtr, m_alusrc, m_pcs;
  logic [1:0] m_flagw;
  logic [3:0] m_aluc, m_cond, m_flags;

  cond_exec_stage dut (
    .CLK(CLK), .RST(RST), .StallE(StallE), .FlushE(FlushE), .ValidD(ValidD), .RegWD(RegWD),
    .MemWD(MemWD), .MemToRegD(MemToRegD), .ALUSrcD(ALUSrcD), .PCSD(PCSD), .FlagWD(FlagWD),
    .ALUControlD(ALUControlD), .CondD(CondD), .ALUFlags(ALUFlags), .ValidE(ValidE),
    .CondExE(CondExE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .PCSrcE(PCSrcE),
    .MemToRegE(MemToRegE), .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE), .Flags(Flags)
`ifdef COND_PERF_CNT_EN
    , .ExecCnt(ExecCnt), .AnnulCnt(AnnulCnt)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cc, v;
    {n, z, cc, v} = f;
    case (c)
      4'd0: return z;
      4'd1: return !z;
      4'd2: return cc;
      4'd3: return !cc;
      4'd4: return n;
      4'd5: return !n;
      4'd6: return v;
      4'd7: return !v;
      4'd8: return cc && !z;
      4'd9: return !cc || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic m_pass();
    return m_valid && cond_ok(m_cond, m_flags);
  endfunction

  task automatic model_reset();
    {m_valid, m_regw, m_memw, m_mtr, m_alusrc, m_pcs} = '0;
    m_flagw = 0; m_aluc = 0; m_cond = 0; m_flags = 0;
`ifdef COND_PERF_CNT_EN
    m_exec = 0; m_annul = 0;
`endif
  endtask

  task automatic model_edge();
    logic p;
    p = m_pass();
`ifdef COND_PERF_CNT_EN
    if (m_valid && !StallE) begin
      if (p) m_exec++;
      else m_annul++;
    end
`endif
    if (p && !StallE) begin
      if (m_flagw[1]) m_flags[3:2] = ALUFlags[3:2];
      if (m_flagw[0]) m_flags[1:0] = ALUFlags[1:0];
    end
    if (FlushE) begin
      {m_valid, m_regw, m_memw, m_mtr, m_alusrc, m_pcs} = '0;
      m_flagw = 0; m_aluc = 0; m_cond = 0;
    end else if (!StallE) begin
      {m_valid, m_regw, m_memw, m_mtr, m_alusrc, m_pcs} = {ValidD, RegWD, MemWD, MemToRegD, ALUSrcD, PCSD};
      m_flagw = FlagWD; m_aluc = ALUControlD; m_cond = CondD;
    end
  endtask

  task automatic check_all();
    logic p;
    p = m_pass();
    chk("valid", ValidE, m_valid);
    chk("condex", CondExE, p);
    chk("regwrite", RegWriteE, m_regw && p);
    chk("memwrite", MemWriteE, m_memw && p);
    chk("pcsrc", PCSrcE, m_pcs && p);
    chk("memtoreg", MemToRegE, m_mtr);
    chk("alusrc", ALUSrcE, m_alusrc);
    chk("aluctl", ALUControlE, m_aluc);
    chk("flags", Flags, m_flags);
`ifdef COND_PERF_CNT_EN
    chk("execcnt", ExecCnt, m_exec);
    chk("annulcnt", AnnulCnt, m_annul);
`endif
  endtask

  task automatic tick();
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
    check_all();
  endtask

  task automatic load(input logic v, input logic rw, input logic [1:0] fw, input logic [3:0] c);
    ValidD = v; RegWD = rw; FlagWD = fw; CondD = c;
    MemWD = rw; PCSD = 0; MemToRegD = 0; ALUSrcD = 0; ALUControlD = c ^ 4'h5;
  endtask

  task automatic set_flags(input logic [3:0] f);
    load(1, 0, 2'b11, 4'he);
    tick();
    ALUFlags = f;
    load(0, 0, 0, 0);
    tick();
    chk("set_flags", Flags, f);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge CLK);
    RST = 1;
    check_all();
`ifdef COND_PERF_CNT_EN
    for (int i = 0; i < 8; i++) begin
      load(1, 1, 0, i < 5 ? 4'he : 4'hf);
      tick();
      if (i == 0) begin
        StallE = 1;
        tick();
        tick();
        StallE = 0;
      end
    end
    load(0, 0, 0, 0);
    tick();
    chk("exec5", ExecCnt, 5);
    chk("annul3", AnnulCnt, 3);
`endif
    // flag setter followed by EQ then NE
    load(1, 0, 2'b11, 4'he);
    tick();
    ALUFlags = 4'b0100;
    load(1, 1, 0, 4'h0);
    tick();
    chk("adds_flags", Flags, 4'b0100);
    chk("moveq_regw", RegWriteE, 1);
    ALUFlags = 4'b1011;
    load(1, 1, 0, 4'h1);
    tick();
    chk("movne_regw", RegWriteE, 0);
    chk("movne_condex", CondExE, 0);
    chk("movne_flags", Flags, 4'b0100);
    // signed compares
    set_flags(4'b1000);
    load(1, 1, 0, 4'ha);
    tick();
    chk("ge_fail", CondExE, 0);
    load(1, 1, 0, 4'hb);
    tick();
    chk("lt_pass", CondExE, 1);
    set_flags(4'b1001);
    load(1, 1, 0, 4'hc);
    tick();
    chk("gt_pass", CondExE, 1);
    load(1, 1, 0, 4'hf);
    tick();
    chk("nv_fail", CondExE, 0);
    // stall a flag setter for 3 cycles
    set_flags(4'b0000);
    load(1, 1, 2'b11, 4'he);
    tick();
    StallE = 1;
    ALUFlags = 4'b1010;
    load(1, 0, 0, 4'h1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_flags", Flags, 4'b0000);
      chk("stall_regw", RegWriteE, 1);
    end
    StallE = 0;
    tick();
    chk("unstall_flags", Flags, 4'b1010);
    load(0, 0, 0, 0);
    tick();
    chk("once_flags", Flags, 4'b1010);
    load(1, 1, 0, 4'he);
    tick();
    FlushE = 1;
    StallE = 1;
    tick();
    chk("flush_stall", ValidE, 0);
    FlushE = 0;
    StallE = 0;
    // partial updates
    set_flags(4'b1111);
    load(1, 0, 2'b01, 4'he);
    tick();
    ALUFlags = 4'b0000;
    load(0, 0, 0, 0);
    tick();
    chk("cv_only", Flags, 4'b1100);
    set_flags(4'b1111);
    load(1, 0, 2'b10, 4'he);
    tick();
    ALUFlags = 4'b0000;
    load(1, 1, 0, 4'he);
    tick();
    chk("nz_only", Flags, 4'b0011);
    // asynchronous reset with a valid instruction in E
    chk("pre_rst_valid", ValidE, 1);
    #2 RST = 0;
    #1;
    model_reset();
    chk("rst_valid", ValidE, 0);
    chk("rst_flags", Flags, 0);
    chk("rst_regw", RegWriteE, 0);
    chk("rst_condex", CondExE, 0);
    check_all();
    RST = 1;
    // randomized stream
    for (int i = 0; i < 600; i++) begin
      StallE = ($urandom_range(3) == 0);
      FlushE = ($urandom_range(7) == 0);
      {ValidD, RegWD, MemWD, MemToRegD, ALUSrcD, PCSD} = 6'($urandom);
      FlagWD = 2'($urandom);
      ALUControlD = 4'($urandom);
      CondD = 4'($urandom);
      ALUFlags = 4'($urandom);
      tick();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
